// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - multiplexed 4-digit 7-segment time display scanner
module display_scan_ctrl #(
    parameter int NUM_SRC   = 2,
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 50000000,
    localparam int SEL_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_SRC*6-1:0] src_s,
    input  logic [NUM_SRC*6-1:0] src_m,
    input  logic [NUM_SRC*5-1:0] src_h,
    input  logic [SEL_W-1:0]     src_sel,
    input  logic                 sel_moh,
    input  logic [1:0]           blink_en,
    output logic [3:0]           an,
    output logic [6:0]           seg,
    output logic                 dp,
    output logic [5:0]           led
);
    localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    logic [SCAN_W-1:0]  scan_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic [1:0]         digit_idx;
    logic               blink_phase;
    logic               scan_tick;
    logic               blink_tick;

    logic [5:0] lat_s;
    logic [5:0] lat_m;
    logic [4:0] lat_h;
    logic       lat_moh;
    logic [1:0] lat_blink;

    logic [5:0] pick_s;
    logic [5:0] pick_m;
    logic [4:0] pick_h;

    logic [5:0] left_val;
    logic [5:0] right_val;
    logic [5:0] slot_val;
    logic [5:0] led_nxt;
    logic       left_bad;
    logic       right_bad;
    logic       slot_bad;
    logic       blank;
    logic [3:0] digit;
    logic [6:0] seg_nxt;
    logic [3:0] an_nxt;
    logic       dp_nxt;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'h40;
            4'd1:    seg_code = 7'h79;
            4'd2:    seg_code = 7'h24;
            4'd3:    seg_code = 7'h30;
            4'd4:    seg_code = 7'h19;
            4'd5:    seg_code = 7'h12;
            4'd6:    seg_code = 7'h02;
            4'd7:    seg_code = 7'h78;
            4'd8:    seg_code = 7'h00;
            4'd9:    seg_code = 7'h10;
            default: seg_code = 7'h7F;
        endcase
    endfunction

    assign scan_tick  = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
    assign blink_tick = (blink_cnt == BLINK_W'(BLINK_DIV - 1));

    // An out-of-range select matches no candidate and falls back to source 0.
    always_comb begin
        pick_s = src_s[5:0];
        pick_m = src_m[5:0];
        pick_h = src_h[4:0];
        for (int k = 1; k < NUM_SRC; k++) begin
            if (src_sel == SEL_W'(k)) begin
                pick_s = src_s[6*k +: 6];
                pick_m = src_m[6*k +: 6];
                pick_h = src_h[5*k +: 5];
            end
        end
    end

    always_comb begin
        if (lat_moh) begin
            left_val  = {1'b0, lat_h};
            right_val = lat_m;
            led_nxt   = lat_s;
            left_bad  = (lat_h > 5'd23);
        end else begin
            left_val  = lat_m;
            right_val = lat_s;
            led_nxt   = {1'b0, lat_h};
            left_bad  = (lat_m > 6'd59);
        end
        right_bad = (right_val > 6'd59);
        // Index 0/1 are the right pair (ones/tens), 2/3 the left pair.
        slot_val  = digit_idx[1] ? left_val : right_val;
        slot_bad  = digit_idx[1] ? left_bad : right_bad;
        digit     = digit_idx[0] ? 4'(slot_val / 6'd10) : 4'(slot_val % 6'd10);
        seg_nxt   = slot_bad ? SEG_DASH : seg_code(digit);
        blank     = blink_phase & lat_blink[digit_idx[1]];
        an_nxt    = blank ? 4'b1111 : ~(4'b0001 << digit_idx);
        dp_nxt    = ~((digit_idx == 2'd2) & ~blink_phase);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt    <= '0;
            blink_cnt   <= '0;
            digit_idx   <= 2'd0;
            blink_phase <= 1'b0;
            lat_s       <= 6'd0;
            lat_m       <= 6'd0;
            lat_h       <= 5'd0;
            lat_moh     <= 1'b0;
            lat_blink   <= 2'b00;
            an          <= 4'b1111;
            seg         <= 7'b1111111;
            dp          <= 1'b1;
            led         <= 6'd0;
        end else begin
            scan_cnt <= scan_tick ? '0 : scan_cnt + 1'b1;
            if (scan_tick) begin
                digit_idx <= digit_idx + 2'd1;
                // Latch only at the frame boundary so a frame never mixes old and new data.
                if (digit_idx == 2'd3) begin
                    lat_s     <= pick_s;
                    lat_m     <= pick_m;
                    lat_h     <= pick_h;
                    lat_moh   <= sel_moh;
                    lat_blink <= blink_en;
                end
            end
            blink_cnt <= blink_tick ? '0 : blink_cnt + 1'b1;
            if (blink_tick) begin
                blink_phase <= ~blink_phase;
            end
            an  <= an_nxt;
            seg <= seg_nxt;
            dp  <= dp_nxt;
            led <= led_nxt;
        end
    end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - self-checking bench for display_scan_ctrl
module tb_display_scan_ctrl;
    localparam int SCAN  = 4;
    localparam int BLINK = 64;
    localparam int FRAME = 4 * SCAN;
    localparam logic [6:0] SEG_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [5:0] led;
    } out_t;

    typedef struct {
        int       s;
        int       m;
        int       h;
        bit       moh;
        bit [1:0] bl;
    } frame_t;

    localparam out_t RESET_OUT = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, led: 6'd0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [11:0] s2, m2;
    logic [9:0]  h2;
    logic [0:0]  sel2;
    logic [17:0] s3, m3;
    logic [14:0] h3;
    logic [1:0]  sel3;
    logic        moh;
    logic [1:0]  blink;
    logic [3:0]  an2, an3;
    logic [6:0]  seg2, seg3;
    logic        dp2, dp3;
    logic [5:0]  led2, led3;

    int checks = 0;
    int failures = 0;
    int c = 0;
    frame_t f2, f3;
    out_t exp2, exp3;
    logic [6:0] seg_cap [4];

    always #5 clk = ~clk;

    display_scan_ctrl #(.NUM_SRC(2), .SCAN_DIV(SCAN), .BLINK_DIV(BLINK)) dut2 (
        .clk(clk), .rst_n(rst_n), .src_s(s2), .src_m(m2), .src_h(h2), .src_sel(sel2),
        .sel_moh(moh), .blink_en(blink), .an(an2), .seg(seg2), .dp(dp2), .led(led2));

    display_scan_ctrl #(.NUM_SRC(3), .SCAN_DIV(SCAN), .BLINK_DIV(BLINK)) dut3 (
        .clk(clk), .rst_n(rst_n), .src_s(s3), .src_m(m3), .src_h(h3), .src_sel(sel3),
        .sel_moh(moh), .blink_en(blink), .an(an3), .seg(seg3), .dp(dp3), .led(led3));

    function automatic frame_t zero_frame();
        frame_t f;
        f.s = 0; f.m = 0; f.h = 0; f.moh = 1'b0; f.bl = 2'b00;
        return f;
    endfunction

    function automatic frame_t pick(input logic [17:0] s, input logic [17:0] m,
                                    input logic [14:0] h, input int sel, input int nsrc,
                                    input logic vm, input logic [1:0] vb);
        frame_t f;
        int k;
        k = (sel >= nsrc) ? 0 : sel;
        f.s = int'((s >> (6 * k)) & 18'h3F);
        f.m = int'((m >> (6 * k)) & 18'h3F);
        f.h = int'((h >> (5 * k)) & 15'h1F);
        f.moh = vm;
        f.bl = vb;
        return f;
    endfunction

    // What the display shows c cycles after reset, given the frame in force.
    function automatic out_t expect_out(input int cyc, input frame_t f);
        out_t o;
        int slot, ph, left, right, val, lim, d;
        bit bad;
        slot = (cyc / SCAN) % 4;
        ph   = (cyc / BLINK) % 2;
        if (f.moh) begin
            left = f.h; right = f.m; o.led = 6'(f.s); lim = 23;
        end else begin
            left = f.m; right = f.s; o.led = 6'(f.h); lim = 59;
        end
        if (slot >= 2) begin
            val = left; bad = (val > lim);
        end else begin
            val = right; bad = (val > 59);
        end
        d = (slot % 2 == 1) ? val / 10 : val % 10;
        o.seg = bad ? 7'h3F : SEG_TAB[d];
        o.an  = (ph == 1 && f.bl[slot / 2]) ? 4'hF : ~(4'b0001 << slot);
        o.dp  = (slot == 2 && ph == 0) ? 1'b0 : 1'b1;
        return o;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            c = 0;
            f2 = zero_frame();
            f3 = zero_frame();
            exp2 = RESET_OUT;
            exp3 = RESET_OUT;
        end else begin
            exp2 = expect_out(c, f2);
            exp3 = expect_out(c, f3);
            if ((c + 1) % FRAME == 0) begin
                f2 = pick({6'd0, s2}, {6'd0, m2}, {5'd0, h2}, int'(sel2), 2, moh, blink);
                f3 = pick(s3, m3, h3, int'(sel3), 3, moh, blink);
            end
            c++;
        end
    end

    task automatic step();
        @(negedge clk);
        checks++;
        assert ({an2, seg2, dp2, led2} === exp2) else begin
            failures++;
            $error("FAIL model_n2 c=%0d observed=%h expected=%h", c, {an2, seg2, dp2, led2}, exp2);
        end
        checks++;
        assert ({an3, seg3, dp3, led3} === exp3) else begin
            failures++;
            $error("FAIL model_n3 c=%0d observed=%h expected=%h", c, {an3, seg3, dp3, led3}, exp3);
        end
        for (int k = 0; k < 4; k++) begin
            if (an2[k] == 1'b0) seg_cap[k] = seg2;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic capture_frame();
        for (int k = 0; k < 4; k++) seg_cap[k] = 7'h7F;
        run(FRAME);
    endtask

    task automatic wait_phase(input int modulus, input int target);
        for (int i = 0; i < modulus && (c % modulus) != target; i++) step();
        check_val("align", 32'(c % modulus), 32'(target));
    endtask

    initial begin
        s2 = '0; m2 = '0; h2 = '0; sel2 = '0;
        s3 = '0; m3 = '0; h3 = '0; sel3 = 2'd3;
        moh = 1'b0; blink = 2'b00;
        run(3);
        check_val("rst_an", 32'(an2), 32'hF);
        check_val("rst_seg", 32'(seg2), 32'h7F);
        check_val("rst_dp", 32'(dp2), 32'h1);
        check_val("rst_led", 32'(led2), 32'h0);

        rst_n = 1'b1;
        capture_frame();
        check_val("zero_frame_seg0", 32'(seg_cap[0]), 32'h40);
        check_val("zero_frame_seg3", 32'(seg_cap[3]), 32'h40);

        // Source 0 = 12:34:56 on both instances; dut3 selects out-of-range 3.
        s2 = {6'd11, 6'd56}; m2 = {6'd22, 6'd34}; h2 = {5'd5, 5'd12};
        s3 = {6'd40, 6'd41, 6'd56}; m3 = {6'd42, 6'd43, 6'd34}; h3 = {5'd20, 5'd21, 5'd12};
        sel2 = 1'b0; moh = 1'b1;
        run(2 * FRAME);
        capture_frame();
        check_val("hm_seg3", 32'(seg_cap[3]), 32'h79);
        check_val("hm_seg2", 32'(seg_cap[2]), 32'h24);
        check_val("hm_seg1", 32'(seg_cap[1]), 32'h30);
        check_val("hm_seg0", 32'(seg_cap[0]), 32'h19);
        check_val("hm_led", 32'(led2), 32'd56);
        check_val("oor_sel_led", 32'(led3), 32'd56);

        wait_phase(FRAME, 5);
        moh = 1'b0;
        run(3);
        check_val("midframe_led", 32'(led2), 32'd56);
        run(2 * FRAME);
        check_val("ms_led", 32'(led2), 32'b001100);
        check_val("oor_sel_ms_led", 32'(led3), 32'd12);

        // Source 1 minutes out of range.
        s2 = {6'd45, 6'd56}; m2 = {6'd60, 6'd34}; h2 = {5'd7, 5'd12};
        sel2 = 1'b1;
        run(2 * FRAME);
        capture_frame();
        check_val("dash_seg3", 32'(seg_cap[3]), 32'h3F);
        check_val("dash_seg2", 32'(seg_cap[2]), 32'h3F);
        check_val("dash_seg1", 32'(seg_cap[1]), 32'h19);
        check_val("dash_seg0", 32'(seg_cap[0]), 32'h12);
        check_val("dash_led", 32'(led2), 32'd7);

        blink = 2'b10; sel2 = 1'b0; moh = 1'b1;
        run(4 * BLINK);

        for (int it = 0; it < 60; it++) begin
            s2 = 12'($urandom); m2 = 12'($urandom); h2 = 10'($urandom);
            s3 = 18'($urandom); m3 = 18'($urandom); h3 = 15'($urandom);
            sel2 = 1'($urandom); sel3 = 2'($urandom);
            moh = 1'($urandom); blink = 2'($urandom);
            run($urandom_range(1, 24));
        end

        wait_phase(SCAN, 2);
        rst_n = 1'b0;
        step();
        check_val("midrst_an", 32'(an2), 32'hF);
        check_val("midrst_led", 32'(led2), 32'h0);
        rst_n = 1'b1;
        step();
        check_val("restart_an", 32'(an2), 32'hE);
        run(3 * FRAME);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
